coeff_pack64: RTL and testbench
===============================

Name: coeff_pack64

Overview:
- Packs a stream of 12-bit polynomial coefficients into 64-bit words, LSB-first, for the SHA-3/Kyber datapath.
- It is the inverse of the 64-to-12 parse stage: every 16 coefficients (192 bits) become exactly 3 output words.
- It frames one polynomial of N_COEFF coefficients per start pulse, flags out-of-range coefficients, and supports valid/ready backpressure on both sides.

Parameters:
- N_COEFF, 256, coefficients per polynomial; must be a nonzero multiple of 16, so 256 gives 48 words.
- Q, 3329, modulus; a coefficient >= Q sets err.

Ports:
- clk  input  1  rising-edge clock
- resetb  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse that begins a polynomial; ignored unless the block is in IDLE
- in_coeff  input  12  coefficient value
- in_valid  input  1  in_coeff is valid
- in_ready  output  1  block accepts in_coeff this cycle
- out_data  output  64  packed word
- out_valid  output  1  out_data is valid
- out_ready  input  1  sink accepts out_data this cycle
- out_last  output  1  qualifies the final word of the polynomial, valid with out_valid
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse after the last word transfers
- err  output  1  sticky flag: a coefficient >= Q was accepted in the current or last polynomial

Behaviour:
- State machine: IDLE -> RUN on start. RUN -> IDLE when the last word is transferred; done pulses for one cycle on that transition.
- Reset (asynchronous, resetb=0): state=IDLE, acc=0, fill=0, coefficient count=0, word count=0, in_ready=0, out_valid=0, out_last=0, busy=0, done=0, err=0.
- Datapath: a 76-bit accumulator acc with a 7-bit fill count, range 0..75.
- Input transfer: occurs when in_valid && in_ready.
  - in_coeff is written into acc[fill+11:fill].
  - fill increases by 12 and the coefficient count increments.
  - If in_coeff >= Q, err is set. The coefficient is still packed unmodified.
- in_ready = (state==RUN) && (fill < 64) && (coefficient count < N_COEFF).
  - in_ready is driven from registers only, with no combinational path from out_ready.
- out_valid = (fill >= 64). out_data = acc[63:0], held stable while out_valid && !out_ready.
- Output transfer: occurs when out_valid && out_ready.
  - acc shifts right by 64 and fill decreases by 64.
  - The word count increments.
- Input and output transfers are mutually exclusive by construction: in_ready=0 whenever fill >= 64.
- Bit order: coefficient k of the polynomial occupies stream bits [12k+11:12k]. Word j carries stream bits [64j+63:64j].
- Cycle pattern per 16-coefficient group:
  - Word 0 = c4..c0 plus c5[3:0].
  - Word 1 = c5[11:4], c6..c9, c10[7:0].
  - Word 2 = c10[11:8], c11..c15.
- Latency: a word is valid the cycle after the input transfer that brings fill to >= 64.
- Unstalled throughput is 16 coefficients per 19 cycles.
- out_last = out_valid && (word count == N_COEFF*12/64 - 1). On that transfer fill returns to 0.
- start handling:
  - In IDLE, start clears err, both counts, acc, and fill, and enters RUN.
  - start during RUN is ignored, and err is not cleared.
- Inputs in IDLE: in_valid is ignored because in_ready=0. out_valid is 0 in IDLE.
- Reset asserted mid-polynomial: all state is lost immediately and the partial polynomial is discarded. No done pulse is issued.
- Upstream starvation (in_valid low) leaves state unchanged. There is no timeout.

Test Plan:
- N_COEFF=16, coefficients c_i = i+1 (0x001..0x010), out_ready=1 -> words 0x6005004003002001, 0x0B00A00900800700, 0x01000F00E00D00C0; out_last on the third word only; done pulses 1 cycle later; err=0.
- Same stimulus with out_ready held low for 5 cycles at each word -> out_data stable while stalled; in_ready=0 throughout each stall; identical word sequence.
- N_COEFF=256, random coefficients < 3329 with random in_valid/out_ready gaps -> 48 words matching a software packer; out_last on word 47; no other out_last; no dropped or duplicated coefficient.
- Coefficient 3 = 0xD01 (3329), rest valid -> err=1 through done and into IDLE; 0xD01 packed unchanged; next start clears err.
- Reset pulse after 10 coefficients, then a fresh start with the scenario 1 data -> outputs exactly as in scenario 1; no done before the reset.
- start pulse mid-polynomial -> no effect on counts, acc, or err.

Source files
------------

// File: rtl/coeff_pack64.sv
// Packs a stream of 12-bit coefficients LSB-first into 64-bit words, one
// polynomial of N_COEFF coefficients per start, with valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for start; no input accepted, no output offered
// RUN   | packing the current polynomial until its last word transfers
module coeff_pack64 #(
  parameter int N_COEFF = 256,
  parameter int Q       = 3329
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        start,
  input  logic [11:0] in_coeff,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int N_WORD = N_COEFF * 12 / 64;
  localparam int CW     = $clog2(N_COEFF + 1);
  localparam int WW     = $clog2(N_WORD + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state, state_n;
  logic          done_n;
  logic [75:0]   acc, acc_n;
  logic [6:0]    fill, fill_n;
  logic [CW-1:0] ccnt, ccnt_n;
  logic [WW-1:0] wcnt, wcnt_n;
  logic          err_n;
  logic          in_fire, out_fire;

  // in_ready depends only on registered state, never on out_ready.
  assign in_ready  = (state == RUN) && (fill < 7'd64) && (ccnt < CW'(N_COEFF));
  assign out_valid = (fill >= 7'd64);
  assign out_data  = acc[63:0];
  assign out_last  = out_valid && (wcnt == WW'(N_WORD - 1));
  assign busy      = (state == RUN);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_n = RUN;
      end
      RUN: begin
        if (out_fire && out_last) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    acc_n  = acc;
    fill_n = fill;
    ccnt_n = ccnt;
    wcnt_n = wcnt;
    err_n  = err;
    if (state == IDLE) begin
      if (start) begin
        acc_n  = '0;
        fill_n = '0;
        ccnt_n = '0;
        wcnt_n = '0;
        err_n  = 1'b0;
      end
    end else if (in_fire) begin
      // Bits at and above fill are always zero, so OR-ing places the coefficient.
      acc_n  = acc | ({64'd0, in_coeff} << fill);
      fill_n = fill + 7'd12;
      ccnt_n = ccnt + CW'(1);
      if (in_coeff >= 12'(Q)) err_n = 1'b1;
    end else if (out_fire) begin
      acc_n  = acc >> 64;
      fill_n = fill - 7'd64;
      wcnt_n = wcnt + WW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      acc  <= '0;
      fill <= '0;
      ccnt <= '0;
      wcnt <= '0;
      err  <= 1'b0;
    end else begin
      acc  <= acc_n;
      fill <= fill_n;
      ccnt <= ccnt_n;
      wcnt <= wcnt_n;
      err  <= err_n;
    end
  end

endmodule

// File: tb/tb_coeff_pack64.sv
// Bench for coeff_pack64: one instance with 16 coefficients per polynomial,
// one with 256, driven by shared tasks and checked against a bit-stream packer.
module tb_coeff_pack64;

  localparam int Q = 3329;

  logic        clk;
  logic        resetb;
  logic        start_s     [2];
  logic [11:0] in_coeff_s  [2];
  logic        in_valid_s  [2];
  logic        in_ready_s  [2];
  logic [63:0] out_data_s  [2];
  logic        out_valid_s [2];
  logic        out_ready_s [2];
  logic        out_last_s  [2];
  logic        busy_s      [2];
  logic        done_s      [2];
  logic        err_s       [2];

  int n_vec = 0;
  int n_err = 0;

  logic [11:0] coef  [256];
  logic [63:0] exp_w [48];

  typedef struct {
    logic [11:0] base;
    logic [11:0] step;
    int          rdy_mode;
    logic [63:0] w0, w1, w2;
    logic        err;
  } vec_t;

  vec_t tab [5];

  coeff_pack64 #(.N_COEFF(16), .Q(Q)) dut0 (
    .clk(clk), .resetb(resetb), .start(start_s[0]),
    .in_coeff(in_coeff_s[0]), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
    .out_data(out_data_s[0]), .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
    .out_last(out_last_s[0]), .busy(busy_s[0]), .done(done_s[0]), .err(err_s[0])
  );

  coeff_pack64 #(.N_COEFF(256), .Q(Q)) dut1 (
    .clk(clk), .resetb(resetb), .start(start_s[1]),
    .in_coeff(in_coeff_s[1]), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
    .out_data(out_data_s[1]), .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
    .out_last(out_last_s[1]), .busy(busy_s[1]), .done(done_s[1]), .err(err_s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: word j is stream bits [64j+63:64j], stream bit s is bit s%12 of coefficient s/12.
  function automatic logic [63:0] model_word(input int j);
    logic [63:0] w;
    logic [11:0] c;
    int          s;
    w = '0;
    for (int b = 0; b < 64; b++) begin
      s    = 64 * j + b;
      c    = coef[s / 12];
      w[b] = c[s % 12];
    end
    return w;
  endfunction

  task automatic fill_model(input int n);
    for (int j = 0; j < n * 3 / 16; j++) exp_w[j] = model_word(j);
  endtask

  // rdy_mode: 0 always ready, 1 stall 5 cycles per word, 2 random.
  // vld_mode: 0 back-to-back, 1 random gaps.
  task automatic run_poly(input int d, input int rdy_mode, input int vld_mode,
                          input int mid_start_at, input int reset_at);
    int          n, nw, ci, wi, cyc, stall;
    bit          fin, err_m, prev_stall, mid_done;
    logic [63:0] prev_data;
    n  = (d == 0) ? 16 : 256;
    nw = n * 3 / 16;
    ci = 0; wi = 0; cyc = 0; stall = 0;
    fin = 0; err_m = 0; prev_stall = 0; mid_done = 0;
    prev_data = '0;
    @(negedge clk);
    start_s[d] = 1'b1;
    @(negedge clk);
    start_s[d] = 1'b0;
    while (!fin) begin
      if (reset_at >= 0 && ci == reset_at) begin
        in_valid_s[d]  = 1'b0;
        out_ready_s[d] = 1'b0;
        resetb = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy_s[d], 0);
        chk("rst_out_valid", out_valid_s[d], 0);
        chk("rst_in_ready", in_ready_s[d], 0);
        chk("rst_done", done_s[d], 0);
        chk("rst_err", err_s[d], 0);
        resetb = 1'b1;
        return;
      end
      if (cyc >= 20000) begin
        n_vec++;
        n_err++;
        $display("FAIL timeout: dut%0d stuck with %0d coeffs, %0d words", d, ci, wi);
        in_valid_s[d] = 1'b0;
        return;
      end
      chk("busy", busy_s[d], 1);
      chk("done_early", done_s[d], 0);
      chk("err", err_s[d], err_m);
      if (prev_stall) begin
        chk("stall_valid", out_valid_s[d], 1);
        chk("stall_data", out_data_s[d], prev_data);
      end
      if (out_valid_s[d] || ci == n) chk("in_ready_low", in_ready_s[d], 0);

      in_valid_s[d] = (ci < n) && (vld_mode == 0 || $urandom_range(3) != 0);
      in_coeff_s[d] = (ci < n) ? coef[ci] : 12'($urandom_range(4095));
      case (rdy_mode)
        0: out_ready_s[d] = 1'b1;
        1: begin
          if (out_valid_s[d] && stall < 5) begin
            out_ready_s[d] = 1'b0;
            stall++;
          end else begin
            out_ready_s[d] = 1'b1;
          end
        end
        default: out_ready_s[d] = ($urandom_range(2) != 0);
      endcase
      start_s[d] = 1'b0;
      if (mid_start_at >= 0 && ci == mid_start_at && !mid_done) begin
        start_s[d] = 1'b1;
        mid_done   = 1;
      end

      if (in_valid_s[d] && in_ready_s[d]) begin
        if (coef[ci] >= 12'(Q)) err_m = 1;
        ci++;
      end
      if (out_valid_s[d]) chk("out_last", out_last_s[d], (wi == nw - 1));
      if (out_valid_s[d] && out_ready_s[d]) begin
        chk($sformatf("word%0d", wi), out_data_s[d], exp_w[wi]);
        wi++;
        stall = 0;
        if (wi == nw) fin = 1;
      end
      prev_stall = out_valid_s[d] && !out_ready_s[d];
      prev_data  = out_data_s[d];
      @(negedge clk);
      cyc++;
    end
    in_valid_s[d]  = 1'b0;
    out_ready_s[d] = 1'b0;
    start_s[d]     = 1'b0;
    chk("done", done_s[d], 1);
    chk("busy_end", busy_s[d], 0);
    chk("err_end", err_s[d], err_m);
    chk("coeff_count", ci, n);
    chk("out_valid_end", out_valid_s[d], 0);
    @(negedge clk);
    chk("done_pulse", done_s[d], 0);
  endtask

  initial begin
    tab[0] = '{12'h001, 12'h001, 0, 64'h6005004003002001, 64'h0B00A00900800700, 64'h01000F00E00D00C0, 1'b0};
    tab[1] = '{12'hABC, 12'h000, 0, 64'hCABCABCABCABCABC, 64'hBCABCABCABCABCAB, 64'hABCABCABCABCABCA, 1'b0};
    tab[2] = '{12'hFFF, 12'h000, 0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b1};
    tab[3] = '{12'h000, 12'h000, 2, 64'h0, 64'h0, 64'h0, 1'b0};
    tab[4] = '{12'h001, 12'h001, 1, 64'h6005004003002001, 64'h0B00A00900800700, 64'h01000F00E00D00C0, 1'b0};

    resetb = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0; in_valid_s[d] = 1'b0; in_coeff_s[d] = '0; out_ready_s[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_in_ready", in_ready_s[d], 0);
      chk("reset_out_valid", out_valid_s[d], 0);
      chk("reset_out_last", out_last_s[d], 0);
      chk("reset_busy", busy_s[d], 0);
      chk("reset_done", done_s[d], 0);
      chk("reset_err", err_s[d], 0);
    end
    resetb = 1'b1;

    // in_valid in IDLE must be ignored
    in_valid_s[0] = 1'b1;
    in_coeff_s[0] = 12'hFFF;
    repeat (3) @(negedge clk);
    chk("idle_in_ready", in_ready_s[0], 0);
    chk("idle_out_valid", out_valid_s[0], 0);
    chk("idle_err", err_s[0], 0);
    in_valid_s[0] = 1'b0;

    for (int e = 0; e < 5; e++) begin
      for (int i = 0; i < 16; i++) coef[i] = 12'(tab[e].base + tab[e].step * 12'(i));
      exp_w[0] = tab[e].w0; exp_w[1] = tab[e].w1; exp_w[2] = tab[e].w2;
      run_poly(0, tab[e].rdy_mode, 0, -1, -1);
      chk($sformatf("tab%0d_err", e), err_s[0], tab[e].err);
    end

    // out-of-range coefficient: sticky into IDLE, cleared by next start
    for (int i = 0; i < 16; i++) coef[i] = 12'(i + 1);
    coef[3] = 12'hD01;
    fill_model(16);
    run_poly(0, 0, 0, -1, -1);
    repeat (3) @(negedge clk);
    chk("err_sticky_idle", err_s[0], 1);
    chk("err_idle_busy", busy_s[0], 0);
    for (int i = 0; i < 16; i++) coef[i] = 12'(i + 1);
    exp_w[0] = tab[0].w0; exp_w[1] = tab[0].w1; exp_w[2] = tab[0].w2;
    run_poly(0, 0, 0, -1, -1);
    chk("err_cleared", err_s[0], 0);

    // reset after 10 coefficients, then a clean polynomial
    run_poly(0, 0, 0, -1, 10);
    run_poly(0, 0, 0, -1, -1);

    // random full-size polynomials with gaps on both sides
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 256; i++) coef[i] = 12'($urandom_range(Q - 1));
      fill_model(256);
      run_poly(1, 2, 1, -1, -1);
    end

    // start pulse mid-polynomial must not restart or clear err
    for (int i = 0; i < 256; i++) coef[i] = 12'($urandom_range(Q - 1));
    coef[2] = 12'd3500;
    fill_model(256);
    run_poly(1, 2, 1, 100, -1);
    chk("mid_start_err", err_s[1], 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
